pwm_duty_meter: RTL

//  Receive-side counterpart of the LED PWM generators: samples an external PWM/pulse train
//  and measures high time and period in clk cycles. Feeds status/readback logic and closed-loop

---
 rtl/pwm_duty_meter_pkg.sv | 18 +
 rtl/pwm_duty_meter_if.sv | 34 +++
 rtl/pwm_in_sync.sv | 80 ++++++++
 rtl/pwm_duty_meter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pwm_duty_meter_pkg.sv
// Shared definitions for the PWM duty meter: FSM state encodings and default sizing.
// PWM_METER_FILTER_EN adds the glitch-filter length default.
package pwm_duty_meter_pkg;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } meter_state_e;

    localparam int DEF_CNT_W   = 32;
    localparam int DEF_TIMEOUT = 1000000;

`ifdef PWM_METER_FILTER_EN
    localparam int DEF_FILT_LEN = 4;
`endif

endpackage

// File: rtl/pwm_duty_meter_if.sv
// Measurement interface: the sampled PWM input plus the per-period results and stuck status.
// The meter drives through the master modport; readback/status logic uses slave.
interface pwm_duty_meter_if
    import pwm_duty_meter_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic             meas_valid;
    logic             stuck;
    logic             stuck_level;

    modport master (
        input  pwm_in,
        output high_cnt,
        output period_cnt,
        output meas_valid,
        output stuck,
        output stuck_level
    );

    modport slave (
        output pwm_in,
        input  high_cnt,
        input  period_cnt,
        input  meas_valid,
        input  stuck,
        input  stuck_level
    );

endinterface

// File: rtl/pwm_in_sync.sv
// 2-FF synchronizer for the asynchronous PWM input with rise/fall detection.
// With PWM_METER_FILTER_EN a stability filter of FILT_LEN cycles sits after the synchronizer.
module pwm_in_sync
    import pwm_duty_meter_pkg::*;
`ifdef PWM_METER_FILTER_EN
#(
    parameter int FILT_LEN = DEF_FILT_LEN
)
`endif
(
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic s_dly_q, s_dly_d;
    logic s;

`ifdef PWM_METER_FILTER_EN
    localparam int FC_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic            filt_q, filt_d;
    logic [FC_W-1:0] stab_q, stab_d;

    // The filtered level follows the raw level only after FILT_LEN consecutive disagreeing cycles.
    always_comb begin
        filt_d = filt_q;
        stab_d = '0;
        if (sync2_q != filt_q) begin
            if (stab_q == FC_W'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                stab_d = stab_q + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q <= 1'b0;
            stab_q <= '0;
        end else begin
            filt_q <= filt_d;
            stab_q <= stab_d;
        end
    end

    assign s = filt_q;
`else
    assign s = sync2_q;
`endif

    always_comb begin
        sync1_d = pwm_in;
        sync2_d = sync1_q;
        s_dly_d = s;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            s_dly_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            s_dly_q <= s_dly_d;
        end
    end

    assign level = s;
    assign rise  = s & ~s_dly_q;
    assign fall  = ~s & s_dly_q;

endmodule

// File: rtl/pwm_duty_meter.sv
// Measures high time and period of an external PWM train in clk cycles, one report per period,
// with a no-edge timeout. PWM_METER_FILTER_EN enables the input glitch filter (FILT_LEN).
//
// state | meaning
// SYNC  | no reference rise yet (after reset or timeout); waiting for a rise
// HIGH  | inside the high phase; period and high counters running
// LOW   | inside the low phase; period counter running, next rise closes the period
module pwm_duty_meter
    import pwm_duty_meter_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = DEF_TIMEOUT
`ifdef PWM_METER_FILTER_EN
    ,
    parameter int FILT_LEN = DEF_FILT_LEN
`endif
) (
    input  logic             clk,
    input  logic             rst,
    pwm_duty_meter_if.master meas_if
);

    localparam int                IDLE_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic s_level, s_rise, s_fall, s_edge;

`ifdef PWM_METER_FILTER_EN
    pwm_in_sync #(.FILT_LEN(FILT_LEN)) u_sync (
`else
    pwm_in_sync u_sync (
`endif
        .clk    (clk),
        .rst    (rst),
        .pwm_in (meas_if.pwm_in),
        .level  (s_level),
        .rise   (s_rise),
        .fall   (s_fall)
    );

    assign s_edge = s_rise | s_fall;

    meter_state_e      state_q, state_d;
    logic [CNT_W-1:0]  per_ctr_q, per_ctr_d;
    logic [CNT_W-1:0]  hi_ctr_q, hi_ctr_d;
    logic [IDLE_W-1:0] idle_ctr_q, idle_ctr_d;
    logic              armed_q, armed_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic              meas_valid_q, meas_valid_d;
    logic              stuck_q, stuck_d;
    logic              stuck_level_q, stuck_level_d;

    always_comb begin
        state_d       = state_q;
        per_ctr_d     = per_ctr_q;
        hi_ctr_d      = hi_ctr_q;
        idle_ctr_d    = idle_ctr_q;
        armed_d       = armed_q;
        high_cnt_d    = high_cnt_q;
        period_cnt_d  = period_cnt_q;
        meas_valid_d  = 1'b0;
        stuck_d       = stuck_q;
        stuck_level_d = stuck_level_q;

        case (state_q)
            ST_SYNC: begin
                if (s_rise) begin
                    state_d   = ST_HIGH;
                    per_ctr_d = CNT_W'(1);
                    hi_ctr_d  = CNT_W'(1);
                end
            end
            ST_HIGH: begin
                per_ctr_d = sat_inc(per_ctr_q);
                if (s_fall) begin
                    state_d = ST_LOW;
                end else begin
                    hi_ctr_d = sat_inc(hi_ctr_q);
                end
            end
            ST_LOW: begin
                if (s_rise) begin
                    period_cnt_d = per_ctr_q;
                    high_cnt_d   = hi_ctr_q;
                    meas_valid_d = 1'b1;
                    stuck_d      = 1'b0;
                    state_d      = ST_HIGH;
                    per_ctr_d    = CNT_W'(1);
                    hi_ctr_d     = CNT_W'(1);
                end else begin
                    per_ctr_d = sat_inc(per_ctr_q);
                end
            end
            default: begin
                state_d   = ST_SYNC;
                per_ctr_d = '0;
                hi_ctr_d  = '0;
            end
        endcase

        // An edge always beats the timeout; after firing, the timer waits for the next edge.
        if (s_edge) begin
            idle_ctr_d = '0;
            armed_d    = 1'b1;
        end else if (armed_q) begin
            if (idle_ctr_q == IDLE_LAST) begin
                stuck_d       = 1'b1;
                stuck_level_d = s_level;
                armed_d       = 1'b0;
                idle_ctr_d    = '0;
                state_d       = ST_SYNC;
                per_ctr_d     = '0;
                hi_ctr_d      = '0;
            end else begin
                idle_ctr_d = idle_ctr_q + IDLE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_SYNC;
            per_ctr_q     <= '0;
            hi_ctr_q      <= '0;
            idle_ctr_q    <= '0;
            armed_q       <= 1'b1;
            high_cnt_q    <= '0;
            period_cnt_q  <= '0;
            meas_valid_q  <= 1'b0;
            stuck_q       <= 1'b0;
            stuck_level_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            per_ctr_q     <= per_ctr_d;
            hi_ctr_q      <= hi_ctr_d;
            idle_ctr_q    <= idle_ctr_d;
            armed_q       <= armed_d;
            high_cnt_q    <= high_cnt_d;
            period_cnt_q  <= period_cnt_d;
            meas_valid_q  <= meas_valid_d;
            stuck_q       <= stuck_d;
            stuck_level_q <= stuck_level_d;
        end
    end

    assign meas_if.high_cnt    = high_cnt_q;
    assign meas_if.period_cnt  = period_cnt_q;
    assign meas_if.meas_valid  = meas_valid_q;
    assign meas_if.stuck       = stuck_q;
    assign meas_if.stuck_level = stuck_level_q;

endmodule
